// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Imported by the divider top and the testbench.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/divider_8bits_iterative_if.sv
// Operand/result valid-ready bundle for the divider.
// The master side drives operands and out_ready; the divider is the slave.
interface divider_8bits_iterative_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 err_div0;
    logic                 err_ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  err_div0, err_ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output err_div0, err_ovf
    );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract divisor.
// Incoming R is always below the divisor, so its top bit is never set.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH:0] w_s;
    logic           w_ge;
    logic           w_unused;

    assign w_s      = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_ge     = (w_s >= {1'b0, i_d});
    assign o_r      = w_ge ? (w_s - {1'b0, i_d}) : w_s;
    assign o_q      = {i_q[WIDTH-2:0], w_ge};
    assign w_unused = i_r[WIDTH];
endmodule

// File: rtl/divider_8bits_iterative.sv
// Sequential restoring divider: 2W/W -> W quotient and remainder,
// one quotient bit per clock, valid/ready on both sides.
module divider_8bits_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    divider_8bits_iterative_if.slave  bus
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_r;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_div0;
    logic               r_ovf;

    logic [WIDTH:0]     w_r_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    assign w_hi = bus.dividend[2*WIDTH-1:WIDTH];
    assign w_lo = bus.dividend[WIDTH-1:0];

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_nxt),
        .o_q (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_d <= bus.divisor;
                        // Errors skip iteration and report saturated quotient
                        if (bus.divisor == '0 || w_hi >= bus.divisor) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_quot      <= '1;
                            r_rem       <= w_lo;
                            r_div0      <= (bus.divisor == '0);
                            r_ovf       <= (bus.divisor != '0);
                        end else begin
                            r_state    <= ST_BUSY;
                            r_in_ready <= 1'b0;
                            r_r        <= {1'b0, w_hi};
                            r_q        <= w_lo;
                            r_cnt      <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_quot      <= w_q_nxt;
                        r_rem       <= w_r_nxt[WIDTH-1:0];
                        r_div0      <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.err_div0  = r_div0;
    assign bus.err_ovf   = r_ovf;
endmodule

// File: tb/tb_divider_8bits_iterative.sv
// Directed and randomized checks for the iterative divider.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_divider_8bits_iterative;
    import div_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divider_8bits_iterative_if #(.WIDTH(8)) bus ();

    divider_8bits_iterative #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(
        input  logic [15:0] dvd,
        input  logic [7:0]  dvs,
        output int          lat,
        output logic [7:0]  q,
        output logic [7:0]  r,
        output logic        d0,
        output logic        ov
    );
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q  = bus.quotient;
        r  = bus.remainder;
        d0 = bus.err_div0;
        ov = bus.err_ovf;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.quotient !== 8'h00 || bus.remainder !== 8'h00 ||
            bus.err_div0 !== 1'b0 || bus.err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b q=%h r=%h d0=%b ov=%b, want 1 0 00 00 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient,
                     bus.remainder, bus.err_div0, bus.err_ovf);
        end
    endtask

    task automatic test_divide();
        logic [15:0] vd [5] = '{16'hFE01, 16'h03E8, 16'h00FF, 16'h0064, 16'h07FF};
        logic [7:0]  vs [5] = '{8'hFF,    8'h07,    8'h01,    8'h0A,    8'h08};
        logic [7:0]  eq [5] = '{8'hFF,    8'h8E,    8'hFF,    8'h0A,    8'hFF};
        logic [7:0]  er [5] = '{8'h00,    8'h06,    8'h00,    8'h00,    8'h07};
        int lat;
        logic [7:0] q, r;
        logic d0, ov;
        for (int i = 0; i < 5; i++) begin
            run_op(vd[i], vs[i], lat, q, r, d0, ov);
            checks++;
            if (lat != 9 || q !== eq[i] || r !== er[i] || d0 !== 1'b0 || ov !== 1'b0) begin
                errors++;
                $display("FAIL divide[%0d] %h/%h: lat=%0d q=%h r=%h d0=%b ov=%b, want 9 %h %h 0 0",
                         i, vd[i], vs[i], lat, q, r, d0, ov, eq[i], er[i]);
            end
            take();
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== eq[i]) begin
                errors++;
                $display("FAIL handoff[%0d]: rdy=%b vld=%b q=%h, want 1 0 %h",
                         i, bus.in_ready, bus.out_valid, bus.quotient, eq[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [7:0] q, r;
        logic d0, ov;
        run_op(16'h1234, 8'h00, lat, q, r, d0, ov);
        checks++;
        if (lat != 1 || q !== 8'hFF || r !== 8'h34 || d0 !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL div0: lat=%0d q=%h r=%h d0=%b ov=%b, want 1 ff 34 1 0",
                     lat, q, r, d0, ov);
        end
        take();
        run_op(16'h0800, 8'h08, lat, q, r, d0, ov);
        checks++;
        if (lat != 1 || q !== 8'hFF || r !== 8'h00 || d0 !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf: lat=%0d q=%h r=%h d0=%b ov=%b, want 1 ff 00 0 1",
                     lat, q, r, d0, ov);
        end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] q, r;
        logic d0, ov;
        run_op(16'h03E8, 8'h07, lat, q, r, d0, ov);
        for (int i = 0; i < 5; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = i[0];
            bus.dividend  = 16'h1234;
            bus.divisor   = 8'h00;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.quotient !== 8'h8E || bus.remainder !== 8'h06 ||
                bus.err_div0 !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b q=%h r=%h d0=%b, want 1 0 8e 06 0",
                         i, bus.out_valid, bus.in_ready, bus.quotient,
                         bus.remainder, bus.err_div0);
            end
        end
        bus.in_valid = 1'b0;
        take();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.remainder !== 8'h06) begin
            errors++;
            $display("FAIL release: rdy=%b vld=%b r=%h, want 1 0 06",
                     bus.in_ready, bus.out_valid, bus.remainder);
        end
    endtask

    task automatic test_reset_busy();
        int lat;
        logic [7:0] q, r;
        logic d0, ov;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'hFE01;
        bus.divisor  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy: rdy=%b vld=%b, want 0 0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.quotient !== 8'h00 || bus.remainder !== 8'h00 ||
            bus.err_div0 !== 1'b0 || bus.err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort: rdy=%b vld=%b q=%h r=%h d0=%b ov=%b, want 1 0 00 00 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient,
                     bus.remainder, bus.err_div0, bus.err_ovf);
        end
        run_op(16'h00FF, 8'h01, lat, q, r, d0, ov);
        checks++;
        if (lat != 9 || q !== 8'hFF || r !== 8'h00 || d0 !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d q=%h r=%h d0=%b ov=%b, want 9 ff 00 0 0",
                     lat, q, r, d0, ov);
        end
        take();
    endtask

    task automatic test_random();
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  eq, er;
        logic        ed0, eov;
        int          elat, n, lat;
        bit          seen, taken;
        for (int k = 0; k < 2000; k++) begin
            dvs = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            dvd = 16'($urandom);
            if (dvs != 0 && $urandom_range(0, 3) != 0)
                dvd[15:8] = 8'($urandom % dvs);
            if (dvs == 0) begin
                ed0 = 1'b1; eov = 1'b0; eq = 8'hFF; er = dvd[7:0]; elat = 1;
            end else if (dvd[15:8] >= dvs) begin
                ed0 = 1'b0; eov = 1'b1; eq = 8'hFF; er = dvd[7:0]; elat = 1;
            end else begin
                ed0 = 1'b0; eov = 1'b0; elat = 9;
                eq = 8'(int'(dvd) / int'(dvs));
                er = 8'(int'(dvd) % int'(dvs));
            end
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            bus.in_valid = 1'b1;
            bus.dividend = dvd;
            bus.divisor  = dvs;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n = 0; seen = 0; taken = 0; lat = 0;
            while (!taken && n < 60) begin
                if (bus.out_valid) begin
                    if (!seen) begin
                        seen = 1;
                        lat  = n + 1;
                        checks++;
                        if (lat != elat || bus.quotient !== eq || bus.remainder !== er ||
                            bus.err_div0 !== ed0 || bus.err_ovf !== eov ||
                            (!ed0 && !eov &&
                             (int'(bus.quotient) * int'(dvs) + int'(bus.remainder) != int'(dvd) ||
                              bus.remainder >= dvs))) begin
                            errors++;
                            $display("FAIL rand[%0d] %h/%h: lat=%0d q=%h r=%h d0=%b ov=%b, want %0d %h %h %b %b",
                                     k, dvd, dvs, lat, bus.quotient, bus.remainder,
                                     bus.err_div0, bus.err_ovf, elat, eq, er, ed0, eov);
                        end
                    end
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (bus.out_ready) taken = 1;
                end else begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                n++;
            end
            bus.out_ready = 1'b0;
            if (!taken) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout[%0d]: result not taken, seen=%b, want taken", k, seen);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_divide();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
